// File: rtl/trivium_ctrl_pkg.sv
// Shared types and constants for the Trivium sequencer: core mode encoding,
// controller FSM state codes and the setup-round count.
package trivium_ctrl_pkg;

  localparam int IV_WIDTH          = 80;
  localparam int TRIV_SETUP_CYCLES = 1152;

  // Mode input of the 8-bit Trivium core.
  typedef enum logic [1:0] {
    TRIV_IDLE  = 2'd0,
    TRIV_SETUP = 2'd1,
    TRIV_GEN   = 2'd2
  } trivium_state_t;

  typedef logic [2:0] trivium_ctrl_state_t;

  localparam trivium_ctrl_state_t ST_IDLE  = 3'd0;
  localparam trivium_ctrl_state_t ST_LOAD  = 3'd1;
  localparam trivium_ctrl_state_t ST_SETUP = 3'd2;
  localparam trivium_ctrl_state_t ST_GEN   = 3'd3;
  localparam trivium_ctrl_state_t ST_DRAIN = 3'd4;

  // The core sees IDLE while loading, and keeps GEN (stalled) while draining
  // so its keystream position is preserved.
  function automatic trivium_state_t core_mode(input trivium_ctrl_state_t st);
    case (st)
      ST_SETUP:         return TRIV_SETUP;
      ST_GEN, ST_DRAIN: return TRIV_GEN;
      default:          return TRIV_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with push/pop and count/empty/full status.
// Pointers wrap modulo DEPTH; a pop on empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage is not reset; pointers and count define validity, and the
  // read port is forced to zero while empty so no stale byte is ever visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: non-blocking assignments throughout so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/trivium_ctrl.sv
// Sequencer and byte collector for the 8-bit Trivium core: load, setup,
// flow-controlled generation into a FIFO, and valid/ready hand-off.
module trivium_ctrl
  import trivium_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int SETUP_CYCLES = TRIV_SETUP_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IV_WIDTH-1:0] key_in,
  input  logic [IV_WIDTH-1:0] iv_in,
  input  logic [15:0]         req_bytes,
  output logic                busy,
  output logic                done,
  output logic [IV_WIDTH-1:0] triv_key,
  output logic [IV_WIDTH-1:0] triv_iv,
  output trivium_state_t      triv_state,
  output logic                triv_stall,
  input  logic [7:0]          triv_byte,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [10:0] SETUP_LAST = 11'(SETUP_CYCLES - 1);

  trivium_ctrl_state_t state;
  trivium_ctrl_state_t state_nxt;

  logic [IV_WIDTH-1:0] key_q;
  logic [IV_WIDTH-1:0] iv_q;
  logic [15:0]         req_q;
  logic [15:0]         issued;
  logic [10:0]         setup_cnt;
  logic                inflight;
  logic                issue;
  logic                pop;
  logic                job_done;
  logic                accept;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         occupancy;
  logic                fifo_empty;
  logic                fifo_full;

  // The byte issued last cycle is already committed, so it counts toward
  // occupancy; this is what makes FIFO overflow impossible.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign issue     = (state == ST_GEN) && (issued < req_q)
                  && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept    = (state == ST_IDLE) && start && (req_bytes != 16'd0);
  assign job_done  = (state == ST_DRAIN) && !inflight && fifo_empty;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // NOTE: default assignment first so every path drives state_nxt and no
  // latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SETUP;
      ST_SETUP: if (setup_cnt == SETUP_LAST) state_nxt = ST_GEN;
      ST_GEN:   if (issue && (issued == req_q - 16'd1)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (job_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      key_q     <= '0;
      iv_q      <= '0;
      req_q     <= '0;
      issued    <= '0;
      setup_cnt <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            key_q  <= key_in;
            iv_q   <= iv_in;
            req_q  <= req_bytes;
            issued <= '0;
          end
        end
        ST_LOAD:  setup_cnt <= '0;
        ST_SETUP: setup_cnt <= setup_cnt + 11'd1;
        ST_GEN:   if (issue) issued <= issued + 16'd1;
        ST_DRAIN: begin
          if (job_done) begin
            key_q  <= '0;
            iv_q   <= '0;
            req_q  <= '0;
            issued <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign done       = job_done;
  assign triv_key   = key_q;
  assign triv_iv    = iv_q;
  assign triv_state = core_mode(state);
  assign triv_stall = ((state == ST_GEN) && !issue) || (state == ST_DRAIN);

  // The core's byte is valid exactly one cycle after its issue cycle.
  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (triv_byte),
    .pop       (pop),
    .pop_data  (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(inflight && fifo_full && !pop));

endmodule
